// File: rtl/error_collector.sv
// Sticky error word collector: per-source edge detection, saturating event
// counters, first-fault capture and a holdoff-gated clear state machine.
module error_collector #(
  parameter int unsigned HOLD_CLOCKS = 24000000,
  parameter int unsigned COUNT_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             error_i,
  input  logic [7:0]             enable_mask_i,
  input  logic                   clear_i,
  input  logic [7:0]             clear_mask_i,
  input  logic [2:0]             count_sel_i,
  output logic [7:0]             error_word_o,
  output logic                   any_error_o,
  output logic                   first_valid_o,
  output logic [2:0]             first_index_o,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   clear_done_o
);

  localparam int unsigned HOLD_W = (HOLD_CLOCKS == 0) ? 1 : $clog2(HOLD_CLOCKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CLOCKS);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             prev_q;
  logic [7:0]             evt;
  logic                   any_evt;
  logic [2:0]             evt_index;
  logic [HOLD_W-1:0]      holdoff_q;
  logic                   exec_ok;
  logic [7:0]             pend_q, pend_d;
  logic                   exec;
  logic [7:0]             exec_mask;
  logic [COUNT_WIDTH-1:0] cnt_q [8];

  assign evt     = error_i & ~prev_q & enable_mask_i;
  assign any_evt = |evt;
  assign exec_ok = (holdoff_q == '0) && !any_evt;

  assign any_error_o = |error_word_o;
  assign count_o     = cnt_q[count_sel_i];

  // Scan from the top so the last write leaves the lowest set index.
  always_comb begin
    evt_index = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (evt[7 - i]) evt_index = 3'(7 - i);
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    exec      = 1'b0;
    exec_mask = '0;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          if (exec_ok) begin
            exec      = 1'b1;
            exec_mask = clear_mask_i;
          end else begin
            pend_d  = clear_mask_i;
            state_d = PENDING;
          end
        end
      end
      PENDING: begin
        if (exec_ok) begin
          exec      = 1'b1;
          exec_mask = pend_q | (clear_i ? clear_mask_i : '0);
          pend_d    = '0;
          state_d   = IDLE;
        end else if (clear_i) begin
          pend_d = pend_q | clear_mask_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pend_q        <= '0;
      prev_q        <= '0;
      holdoff_q     <= '0;
      error_word_o  <= '0;
      first_valid_o <= 1'b0;
      first_index_o <= '0;
      clear_done_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      prev_q       <= error_i;
      clear_done_o <= exec;

      if (any_evt) holdoff_q <= HOLD_LOAD;
      else if (holdoff_q != '0) holdoff_q <= holdoff_q - HOLD_W'(1);

      // Execute never coincides with an event, so clear-then-set is safe.
      error_word_o <= (error_word_o & ~(exec ? exec_mask : '0)) | evt;

      if (exec && exec_mask[first_index_o]) begin
        first_valid_o <= 1'b0;
        first_index_o <= '0;
      end else if (!first_valid_o && any_evt) begin
        first_valid_o <= 1'b1;
        first_index_o <= evt_index;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 8; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (exec && exec_mask[i]) cnt_q[i] <= '0;
        else if (evt[i] && cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + COUNT_WIDTH'(1);
      end
    end
  end

endmodule
